// File: rtl/l1b_onbellek.sv
// Direct-mapped L1 instruction cache for the fetch stage: combinational lookup,
// single-word refills from memory, and a full invalidate for fence.i.
module l1b_onbellek #(
    parameter int SATIR_SAYISI = 64,
    parameter int IDX_W        = $clog2(SATIR_SAYISI)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:1] gtr_adr_i,
    output logic [31:0] gtr_deger_o,
    output logic        gtr_bekle_o,
    input  logic        ddb_temizle_i,
    output logic        bellek_istek_o,
    output logic [31:2] bellek_adr_o,
    input  logic        bellek_gecerli_i,
    input  logic [31:0] bellek_veri_i
);
    localparam int ETIKET_W = 30 - IDX_W;

    typedef enum logic {BOSTA, BELLEK_BEKLE} durum_t;

    durum_t      durum_reg, durum_next;
    logic        istek_reg, istek_next;
    logic [29:0] adr_reg, adr_next;
    logic        at_reg, at_next;

    logic [31:0]             veri   [SATIR_SAYISI];
    logic [ETIKET_W-1:0]     etiket [SATIR_SAYISI];
    logic [SATIR_SAYISI-1:0] gecerli_reg;
    logic [SATIR_SAYISI-1:0] satir_yaz;

    logic [29:0]         kelime0, kelime1;
    logic [IDX_W-1:0]    idx0, idx1, dolum_idx;
    logic [ETIKET_W-1:0] etiket0, etiket1, dolum_etiket;
    logic                ikinci_gerekli, isabet0, isabet1, isabet;
    logic                dolum_yaz;

    // A halfword-aligned fetch at adr[1]=1 straddles into the next word (wraps mod 2^30).
    assign kelime0        = gtr_adr_i[31:2];
    assign kelime1        = kelime0 + 30'd1;
    assign ikinci_gerekli = gtr_adr_i[1];
    assign idx0           = kelime0[IDX_W-1:0];
    assign idx1           = kelime1[IDX_W-1:0];
    assign etiket0        = kelime0[29:IDX_W];
    assign etiket1        = kelime1[29:IDX_W];

    assign isabet0 = gecerli_reg[idx0] && (etiket[idx0] == etiket0);
    assign isabet1 = gecerli_reg[idx1] && (etiket[idx1] == etiket1);
    assign isabet  = isabet0 && (!ikinci_gerekli || isabet1);

    assign gtr_deger_o = ikinci_gerekli ? {veri[idx1][15:0], veri[idx0][31:16]} : veri[idx0];
    assign gtr_bekle_o = (durum_reg == BELLEK_BEKLE) || !isabet;

    assign bellek_istek_o = istek_reg;
    assign bellek_adr_o   = adr_reg;

    // The outstanding request address doubles as the fill target.
    assign dolum_idx    = adr_reg[IDX_W-1:0];
    assign dolum_etiket = adr_reg[29:IDX_W];
    assign dolum_yaz    = (durum_reg == BELLEK_BEKLE) && bellek_gecerli_i
                          && !at_reg && !ddb_temizle_i;

    always_comb begin
        durum_next = durum_reg;
        istek_next = istek_reg;
        adr_next   = adr_reg;
        at_next    = at_reg;
        case (durum_reg)
            BOSTA: begin
                if (!isabet) begin
                    durum_next = BELLEK_BEKLE;
                    istek_next = 1'b1;
                    adr_next   = isabet0 ? kelime1 : kelime0;
                end
            end
            BELLEK_BEKLE: begin
                if (bellek_gecerli_i) begin
                    durum_next = BOSTA;
                    istek_next = 1'b0;
                    at_next    = 1'b0;
                end else if (ddb_temizle_i) begin
                    // Fill fetched before the invalidate must not become valid.
                    at_next = 1'b1;
                end
            end
            default: durum_next = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_reg <= BOSTA;
            istek_reg <= 1'b0;
            adr_reg   <= '0;
            at_reg    <= 1'b0;
        end else begin
            durum_reg <= durum_next;
            istek_reg <= istek_next;
            adr_reg   <= adr_next;
            at_reg    <= at_next;
        end
    end

    for (genvar gi = 0; gi < SATIR_SAYISI; gi++) begin : g_satir_yaz
        assign satir_yaz[gi] = dolum_yaz && (dolum_idx == IDX_W'(gi));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gecerli_reg <= '0;
        end else if (ddb_temizle_i) begin
            gecerli_reg <= '0;
        end else begin
            gecerli_reg <= gecerli_reg | satir_yaz;
        end
    end

    always_ff @(posedge clk_i) begin
        if (dolum_yaz) begin
            veri[dolum_idx]   <= bellek_veri_i;
            etiket[dolum_idx] <= dolum_etiket;
        end
    end

endmodule

// File: tb/tb_l1b_onbellek.sv
// Scoreboard bench for l1b_onbellek: directed fetches with a latency-programmable memory model.
module tb_l1b_onbellek;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:1] gtr_adr;
    logic [31:0] gtr_deger;
    logic        gtr_bekle;
    logic        ddb;
    logic        istek;
    logic [31:2] badr;
    logic        bgecerli;
    logic [31:0] bveri;

    l1b_onbellek #(.SATIR_SAYISI(64)) dut (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .gtr_adr_i        (gtr_adr),
        .gtr_deger_o      (gtr_deger),
        .gtr_bekle_o      (gtr_bekle),
        .ddb_temizle_i    (ddb),
        .bellek_istek_o   (istek),
        .bellek_adr_o     (badr),
        .bellek_gecerli_i (bgecerli),
        .bellek_veri_i    (bveri)
    );

    always #5 clk = ~clk;

    typedef struct { logic [29:0] adr; int len; } req_t;
    typedef struct { logic [31:0] deger; int lat; int cyc0; } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];
    resp_t mon_r;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    lat = 2;
    logic  istek_prev = 1'b0;
    bit    req_active = 1'b0;
    int    req_t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [29:0] a);
        case (a)
            30'h20:       return 32'h00500093;
            30'h40:       return 32'hAAAA1111;
            30'h41:       return 32'h2222BBBB;
            30'h60:       return 32'h12345678;
            30'h80:       return 32'h0F0F1234;
            30'hC0:       return 32'h600DF00D;
            30'h3FFFFFFF: return 32'h7777CCCC;
            30'h0:        return 32'hDDDD5555;
            30'h100:      return 32'h11112222;
            30'h101:      return 32'h33334444;
            default:      return {2'b11, a};
        endcase
    endfunction

    // Memory model: answers `lat` cycles after the request rises.
    initial begin
        int cnt;
        cnt = 0;
        bgecerli = 1'b0;
        bveri = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || !istek) begin
                bgecerli = 1'b0;
                cnt = 0;
            end else if (cnt == lat) begin
                bgecerli = 1'b1;
                bveri = mem_rd(badr);
                cnt = 0;
            end else begin
                bgecerli = 1'b0;
                cnt++;
            end
        end
    end

    // Monitor: request address/length and fetch responses against the queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            istek_prev = 1'b0;
            req_active = 1'b0;
            req_q.delete();
        end else begin
            if (istek && !istek_prev) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected got=%h want=none", badr);
                end else begin
                    chk("req_adr", 32'(badr), 32'(req_q[0].adr));
                    req_active = 1'b1;
                    req_t0 = cyc;
                end
            end
            if (!istek && istek_prev && req_active) begin
                chk("req_len", cyc - req_t0, req_q[0].len);
                $display("req adr=%h len=%0d", req_q[0].adr, cyc - req_t0);
                void'(req_q.pop_front());
                req_active = 1'b0;
            end
            istek_prev = istek;
            if (resp_q.size() != 0 && !gtr_bekle) begin
                mon_r = resp_q.pop_front();
                chk("resp_data", gtr_deger, mon_r.deger);
                chk("resp_lat", cyc - mon_r.cyc0, mon_r.lat);
                $display("resp adr=%h data=%h lat=%0d", {gtr_adr, 1'b0}, gtr_deger, cyc - mon_r.cyc0);
            end
        end
    end

    task automatic exp_req(input logic [29:0] a);
        req_q.push_back('{a, lat + 1});
    endtask

    task automatic fetch(input logic [31:0] bayt, input logic [31:0] deger, input int gecikme);
        gtr_adr = bayt[31:1];
        resp_q.push_back('{deger, gecikme, cyc});
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || req_q.size() != 0 || istek) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL timeout got=%0d_pending want=0", resp_q.size() + req_q.size());
            resp_q.delete();
            req_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_istek();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!istek && n < 50);
        if (!istek) begin
            checks++;
            errors++;
            $display("FAIL istek_timeout got=0 want=1");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        gtr_adr = 31'h40;
        ddb = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_istek", 32'(istek), 32'd0);
        chk("rst_adr", 32'(badr), 32'd0);
        chk("rst_bekle", 32'(gtr_bekle), 32'd1);

        // Cold miss out of reset
        lat = 2;
        rst_n = 1'b1;
        exp_req(30'h20);
        fetch(32'h80, 32'h00500093, 4);
        wait_done();

        // Hit
        fetch(32'h80, 32'h00500093, 0);
        wait_done();

        // Straddle, both words missing
        lat = 1;
        exp_req(30'h40);
        exp_req(30'h41);
        fetch(32'h102, 32'hBBBBAAAA, 6);
        wait_done();

        // Conflict on index 0x20
        lat = 0;
        exp_req(30'h60);
        fetch(32'h180, 32'h12345678, 2);
        wait_done();
        exp_req(30'h20);
        fetch(32'h80, 32'h00500093, 2);
        wait_done();

        // Invalidate while a fill is outstanding
        lat = 3;
        exp_req(30'h80);
        exp_req(30'h80);
        fetch(32'h200, 32'h0F0F1234, 10);
        wait_istek();
        ddb = 1'b1;
        @(posedge clk); #1;
        ddb = 1'b0;
        wait_done();
        lat = 1;
        exp_req(30'h20);
        fetch(32'h80, 32'h00500093, 3);
        wait_done();

        // Invalidate in the same cycle as the fill
        lat = 2;
        exp_req(30'hC0);
        exp_req(30'hC0);
        fetch(32'h300, 32'h600DF00D, 8);
        wait_istek();
        repeat (lat) begin
            @(posedge clk); #1;
        end
        ddb = 1'b1;
        @(posedge clk); #1;
        ddb = 1'b0;
        wait_done();

        // Address wrap
        lat = 1;
        exp_req(30'h3FFFFFFF);
        exp_req(30'h0);
        fetch(32'hFFFFFFFE, 32'h55557777, 6);
        wait_done();

        // Redirect mid-miss: old word still cached
        lat = 3;
        exp_req(30'h100);
        gtr_adr = 31'h200;
        wait_istek();
        exp_req(30'h101);
        fetch(32'h404, 32'h33334444, 9);
        wait_done();
        fetch(32'h400, 32'h11112222, 0);
        wait_done();

        // Reset mid-refill: request drops at once, lines invalidated
        lat = 5;
        exp_req(30'h200);
        gtr_adr = 31'h400;
        wait_istek();
        rst_n = 1'b0;
        #1;
        chk("rst_async_istek", 32'(istek), 32'd0);
        chk("rst_async_bekle", 32'(gtr_bekle), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        gtr_adr = 31'h202;
        lat = 0;
        rst_n = 1'b1;
        exp_req(30'h101);
        fetch(32'h404, 32'h33334444, 2);
        wait_done();

        chk("queues_empty", 32'(req_q.size() + resp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
